adc_capture: RTL

Single-shot ADC waveform capture block for the signal-generator board: it samples an 8-bit ADC (AD9280-class) that digitises the DDS/DAC output and waits for a rising level crossing. It then stores a 512-sample record in internal block RAM and exposes the record through a registered read port. It also measures signal period (rising-crossing to rising-crossing) and peak-to-peak amplitude of each record, closing the loop on the DAC path for self-test and display.

---
 rtl/adc_capture_if.sv | 28 ++
 rtl/adc_capture.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/adc_capture_if.sv
// Capture control, status, measurement and readback signals of adc_capture.
// The master side drives samples, trigger level, arm and reads; the slave is the capture block.
interface adc_capture_if #(
    parameter int unsigned DEPTH_LOG2 = 9
);
    logic [7:0]            adc_data;
    logic [7:0]            trig_level;
    logic                  arm;
    logic                  busy;
    logic                  done;
    logic                  auto_trig;
    logic                  rd_en;
    logic [DEPTH_LOG2-1:0] rd_addr;
    logic [7:0]            rd_data;
    logic [31:0]           period;
    logic                  period_valid;
    logic [7:0]            vpp;

    modport master (
        output adc_data, trig_level, arm, rd_en, rd_addr,
        input  busy, done, auto_trig, rd_data, period, period_valid, vpp
    );

    modport slave (
        input  adc_data, trig_level, arm, rd_en, rd_addr,
        output busy, done, auto_trig, rd_data, period, period_valid, vpp
    );
endinterface

// File: rtl/adc_capture.sv
// Single-shot ADC record capture with rising-crossing trigger, period and peak-to-peak measurement.
// Optional timeout trigger is built only when ADC_CAPTURE_AUTOTRIG_EN is defined.
module adc_capture #(
    parameter int unsigned DEPTH_LOG2   = 9,
    parameter int unsigned AUTO_TIMEOUT = 1048576
) (
    input  logic          adc_clk,
    input  logic          rst,
    output logic          ad9280_clk,
    adc_capture_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StWaitTrig, StCapture, StDone} state_e;

    state_e                state_q;
    logic [7:0]            s0_q, s1_q;
    logic                  crossing;
    logic                  timeout;
    logic                  trig_start;
    logic                  mem_we;
    logic [7:0]            mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wr_addr_q;
    logic [7:0]            max_q, min_q, nxt_max, nxt_min;
    logic                  busy_q, done_q, auto_trig_q;
    logic [7:0]            vpp_q, rd_data_q;
    logic [31:0]           cnt_q, period_q;
    logic                  seen_q, period_valid_q;

    assign ad9280_clk = adc_clk;

    always_ff @(posedge adc_clk) begin
        if (rst) begin
            s0_q <= 8'd0;
            s1_q <= 8'd0;
        end else begin
            s0_q <= bus.adc_data;
            s1_q <= s0_q;
        end
    end

    assign crossing = (s1_q < bus.trig_level) && (s0_q >= bus.trig_level);

`ifdef ADC_CAPTURE_AUTOTRIG_EN
    logic [31:0] tcnt_q;

    // Held at zero outside WAIT_TRIG, so it restarts on every entry.
    always_ff @(posedge adc_clk) begin
        if (rst || state_q != StWaitTrig) tcnt_q <= 32'd0;
        else                              tcnt_q <= tcnt_q + 32'd1;
    end

    assign timeout       = (tcnt_q == 32'(AUTO_TIMEOUT - 1));
    assign bus.auto_trig = auto_trig_q;
`else
    logic unused_cfg;

    assign unused_cfg    = ^AUTO_TIMEOUT ^ auto_trig_q;
    assign timeout       = 1'b0;
    assign bus.auto_trig = 1'b0;
`endif

    assign trig_start = (state_q == StWaitTrig) && (crossing || timeout);
    assign mem_we     = trig_start || (state_q == StCapture);
    assign nxt_max    = (s0_q > max_q) ? s0_q : max_q;
    assign nxt_min    = (s0_q < min_q) ? s0_q : min_q;

    always_ff @(posedge adc_clk) begin
        if (rst) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            auto_trig_q <= 1'b0;
            vpp_q       <= 8'd0;
            wr_addr_q   <= '0;
            max_q       <= 8'd0;
            min_q       <= 8'd0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (bus.arm) begin
                        state_q     <= StWaitTrig;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        auto_trig_q <= 1'b0;
                        wr_addr_q   <= '0;
                    end
                end
                StWaitTrig: begin
                    if (trig_start) begin
                        state_q     <= StCapture;
                        wr_addr_q   <= wr_addr_q + 1'b1;
                        max_q       <= s0_q;
                        min_q       <= s0_q;
                        // A real crossing takes precedence on the timeout edge.
                        auto_trig_q <= !crossing;
                    end
                end
                StCapture: begin
                    wr_addr_q <= wr_addr_q + 1'b1;
                    max_q     <= nxt_max;
                    min_q     <= nxt_min;
                    if (&wr_addr_q) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        vpp_q   <= nxt_max - nxt_min;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Record RAM has no reset so it maps onto block RAM.
    always_ff @(posedge adc_clk) begin
        if (mem_we) mem[wr_addr_q] <= s0_q;
    end

    always_ff @(posedge adc_clk) begin
        if (rst)             rd_data_q <= 8'd0;
        else if (bus.rd_en)  rd_data_q <= mem[bus.rd_addr];
    end

    always_ff @(posedge adc_clk) begin
        if (rst) begin
            cnt_q          <= 32'd0;
            period_q       <= 32'd0;
            seen_q         <= 1'b0;
            period_valid_q <= 1'b0;
        end else begin
            period_valid_q <= 1'b0;
            if (crossing) begin
                cnt_q  <= 32'd1;
                seen_q <= 1'b1;
                if (seen_q) begin
                    period_q       <= cnt_q;
                    period_valid_q <= 1'b1;
                end
            end else if (cnt_q != 32'hFFFF_FFFF) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.vpp          = vpp_q;
    assign bus.rd_data      = rd_data_q;
    assign bus.period       = period_q;
    assign bus.period_valid = period_valid_q;
endmodule
